// File: rtl/gate_eval_pipe.sv
// gate_eval_pipe: two-stage pipelined, mode-selectable bitwise gate evaluator
// with a valid/ready handshake on both sides.
//
//   mode 0: Y = ~(~A & ~B) | C    mode 1: Y = (A & B) | C
//   mode 2: Y = (A ^ B) | C       mode 3: Y = ~(A | B) & C
//
// Stage 1 holds t = f1(A,B) with C and mode; stage 2 holds Y = t op C.
// Optional feature macro GATE_EVAL_EVT_CNT_EN: when defined, a saturating
// counter accumulates the number of output bits that toggle between
// successive output transfers (cleared by evt_clr). When undefined, evt_cnt
// is tied to zero and evt_clr is ignored.
module gate_eval_pipe #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_mode,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             evt_clr,
  output logic [CNT_W-1:0] evt_cnt
);

  typedef enum logic [1:0] {
    MODE_OR3    = 2'd0,
    MODE_AND_OR = 2'd1,
    MODE_XOR_OR = 2'd2,
    MODE_NOR_AND = 2'd3
  } mode_e;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_t;
  logic [WIDTH-1:0] s1_c;
  mode_e            s1_mode;
  logic             s2_valid;
  logic [WIDTH-1:0] data_q;

  logic             s1_adv;
  logic             s2_adv;
  logic [WIDTH-1:0] t_next;
  logic [WIDTH-1:0] y_next;

  // A stage may load when it is empty or its content moves on this cycle;
  // chaining through out_ready lets a full pipe keep streaming without a bubble.
  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid;
  assign out_data  = data_q;

  // First-level function of A and B, selected by the incoming mode.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    t_next = '0;
    case (mode_e'(in_mode))
      MODE_OR3:     t_next = ~(~in_a & ~in_b);
      MODE_AND_OR:  t_next = in_a & in_b;
      MODE_XOR_OR:  t_next = in_a ^ in_b;
      MODE_NOR_AND: t_next = ~(in_a | in_b);
      default:      t_next = '0;
    endcase
  end

  // Second-level combine with C: AND for the NOR mode, OR for the rest.
  always_comb begin
    y_next = s1_t | s1_c;
    if (s1_mode == MODE_NOR_AND) y_next = s1_t & s1_c;
  end

  // Stage 1 register: capture operands whenever the stage can advance.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement or block order.
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_t     <= '0;
      s1_c     <= '0;
      s1_mode  <= MODE_OR3;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_t    <= t_next;
        s1_c    <= in_c;
        s1_mode <= mode_e'(in_mode);
      end
    end
  end

  // Stage 2 register: result holds while stalled, loads when stage 2 advances.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      data_q   <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) data_q <= y_next;
    end
  end

`ifdef GATE_EVAL_EVT_CNT_EN
  localparam int POP_W = $clog2(WIDTH + 1);

  logic             out_xfer;
  logic [WIDTH-1:0] last_out;
  logic [WIDTH-1:0] diff;
  logic [POP_W-1:0] pop;
  logic [CNT_W:0]   sum;
  logic [CNT_W-1:0] cnt_q;

  assign out_xfer = s2_valid && out_ready;
  assign diff     = data_q ^ last_out;
  assign evt_cnt  = cnt_q;

  // Popcount of toggled bits; the extra sum bit flags saturation.
  always_comb begin
    pop = '0;
    for (int i = 0; i < WIDTH; i++) pop = pop + POP_W'(diff[i]);
    sum = {1'b0, cnt_q} + (CNT_W + 1)'(pop);
  end

  // Counter and previous-output tracking; clear beats a coincident transfer
  // but the transferred value still becomes the new reference.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_out <= '0;
      cnt_q    <= '0;
    end else begin
      if (out_xfer) last_out <= data_q;
      if (evt_clr) begin
        cnt_q <= '0;
      end else if (out_xfer) begin
        cnt_q <= sum[CNT_W] ? '1 : sum[CNT_W-1:0];
      end
    end
  end
`else
  logic unused_evt_clr;

  assign unused_evt_clr = evt_clr;
  assign evt_cnt        = '0;
`endif

endmodule

// File: doc/gate_eval_pipe.md
Name: gate_eval_pipe

Overview:
- Parametrised, pipelined successor to the team's fixed 3-input gate test circuits (NOT/AND/OR networks computing F = f(A,B) op C).
- Evaluates a mode-selectable two-level gate function bitwise on WIDTH-bit vectors.
- Two register stages; valid/ready handshake with backpressure.
- Optional output-transition event counter gives the event-driven simulator a known toggle count to compare against.

Parameters:
- WIDTH, 4, bit width of each operand vector and of the result.
- CNT_W, 16, width of the saturating transition event counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  operand set present.
- in_ready  output  1  block accepts operands this cycle.
- in_mode  input  2  function select, sampled with operands.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_c  input  WIDTH  operand C.
- out_valid  output  1  result present.
- out_ready  input  1  downstream accepts result.
- out_data  output  WIDTH  result Y.
- evt_clr  input  1  synchronous clear of event counter.
- evt_cnt  output  CNT_W  accumulated output bit transitions.

Behaviour:
- Functions, bitwise:
  - mode 0: Y = ~(~A & ~B) | C (classic circuit, equals A|B|C).
  - mode 1: Y = (A & B) | C.
  - mode 2: Y = (A ^ B) | C.
  - mode 3: Y = ~(A | B) & C.
- Stage 1 registers t = f1(A,B), plus C and mode. Stage 2 registers Y = t op C.
- Handshake:
  - Input transfer when in_valid & in_ready; output transfer when out_valid & out_ready.
  - s2_adv = !s2_valid | out_ready.
  - s1_adv = !s1_valid | s2_adv.
  - in_ready = s1_adv (combinational from out_ready, no bubble).
- Latency: transfer at edge N -> out_valid high after edge N+1 when unstalled, i.e. 2 cycles.
- Throughput: 1 result per cycle when out_ready is held high.
- Stall: out_data and out_valid hold stable while out_valid & !out_ready. No data is lost or duplicated; a full pipe holds exactly 2 entries.
- Simultaneous events: a full pipe with out_ready=1 and in_valid=1 accepts the new operands and emits the old result in the same cycle.
- Reset (asynchronous, any time, including mid-transfer):
  - s1_valid = s2_valid = 0, out_data = 0, evt_cnt = 0, last_out = 0.
  - in_ready = 1 during and after reset.
  - In-flight data is discarded.
- Event counter, updated per output transfer:
  - evt_cnt += popcount(out_data ^ last_out), then last_out = out_data.
  - Saturates at 2^CNT_W-1; no wrap.
- evt_clr:
  - Forces evt_cnt = 0 next edge.
  - If it coincides with an output transfer, clear wins: that transfer's count is discarded, but last_out still updates.
- Width rules: popcount is ceil(log2(WIDTH+1)) bits, zero-extended before addition; the sum is computed at CNT_W+1 bits for saturation detection.

Optional Feature:
- Macro GATE_EVAL_EVT_CNT_EN.
- Defined: event counter, last_out register and evt_clr function as above.
- Undefined: counter logic is absent, evt_cnt is tied to 0, and evt_clr is ignored. Datapath and handshake are identical in both builds.

Test Plan:
- Reset then mode 0, A=0000 B=0000 C=0000, out_ready=1 -> out_data=0000 two cycles later; then A=0101 B=0000 C=1000 -> 1101, evt_cnt=3.
- Modes 1/2/3 with A=1100 B=1010 C=0001 -> 1001, 0111, 0001 respectively; back-to-back inputs give 1 result/cycle with order preserved.
- Backpressure: 4 inputs, out_ready=0 -> in_ready drops after 2 accepted and out_data holds. Release -> all 4 results emitted in order, none lost.
- Saturation with CNT_W=4, alternating outputs 0000/1111 -> evt_cnt reaches 15 and stays. evt_clr asserted coincident with a transfer -> evt_cnt=0, and the next transfer counts from the updated last_out.
- rst_n pulsed low mid-stream, asynchronous to clk -> out_valid=0 and evt_cnt=0 immediately; the next input after release behaves as after a power-up reset.
- Build without GATE_EVAL_EVT_CNT_EN -> evt_cnt=0 throughout the same streams; out_data matches the counter-enabled build cycle for cycle.
